// File: rtl/sd_bitstream_decimator.sv
// Sinc2 CIC decimator for the 3-bit sigma-delta link, with a
// valid/ready output register and sticky overrun flag.
module sd_bitstream_decimator #(
  parameter int DECIM_LOG2 = 6,
  parameter int BITWIDTH   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [2:0]          sd_in,
  output logic [BITWIDTH-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                overrun,
  input  logic                clr_ovr
);

  localparam int IW = 2*DECIM_LOG2 + 3;

  logic [1:0]            ones;
  logic signed [2:0]     x;
  logic [IW-1:0]         x_ext;

  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [IW-1:0]         i1_q, i1_d;
  logic [IW-1:0]         i2_q, i2_d;
  logic [IW-1:0]         s_q, s_d;
  logic [IW-1:0]         c1_q, c1_d;
  logic [IW-1:0]         c1, c2;
  logic [1:0]            prime_q, prime_d;
  logic [BITWIDTH-1:0]   dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic                  boundary;
  logic                  new_smp;

  assign ones = {1'b0, sd_in[0]}
              + {1'b0, sd_in[1]}
              + {1'b0, sd_in[2]};

  always_comb begin
    x = 3'sd0;
    unique case (ones)
      2'd0: x = -3'sd3;
      2'd1: x = -3'sd1;
      2'd2: x = 3'sd1;
      2'd3: x = 3'sd3;
      default: x = 3'sd0;
    endcase
  end

  assign x_ext = {{(IW-3){x[2]}}, x};

  assign boundary = en && (cnt_q == '1);
  assign new_smp  = boundary && (prime_q == 2'd2);

  assign i1_d = i1_q + x_ext;
  assign i2_d = i2_q + i1_d;
  assign c1   = i2_d - s_q;
  assign c2   = c1 - c1_q;

  always_comb begin
    cnt_d   = cnt_q;
    s_d     = s_q;
    c1_d    = c1_q;
    prime_d = prime_q;
    if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (boundary) begin
      s_d  = i2_d;
      c1_d = c1;
      if (prime_q != 2'd2) begin
        prime_d = prime_q + 2'd1;
      end
    end
  end

  // A new sample may only replace dout if the old one
  // is gone or leaves in this same cycle.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (new_smp) begin
      if (!valid_q || dout_ready) begin
        dout_d  = BITWIDTH'($signed(c2));
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      i1_q    <= '0;
      i2_q    <= '0;
      s_q     <= '0;
      c1_q    <= '0;
      prime_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      if (en) begin
        i1_q <= i1_d;
        i2_q <= i2_d;
      end
      s_q     <= s_d;
      c1_q    <= c1_d;
      prime_q <= prime_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sd_bitstream_decimator.sv
// Bench for sd_bitstream_decimator: triangular-FIR reference
// model at D=8 plus a long constant-input run at D=64.
module tb_sd_bitstream_decimator;

  localparam int L = 3;
  localparam int D = 8;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, en, rdy, clr;
  logic [2:0]   sd;
  logic [W-1:0] dout;
  logic         vld, ovr;

  logic         rst64, en64, rdy64, clr64;
  logic [2:0]   sd64;
  logic [W-1:0] dout64;
  logic         vld64, ovr64;

  int tests = 0;
  int fails = 0;
  int nprint = 0;

  sd_bitstream_decimator #(.DECIM_LOG2(L), .BITWIDTH(W)) dut (
    .clk(clk), .reset(rst_n), .en(en), .sd_in(sd),
    .dout(dout), .dout_valid(vld), .dout_ready(rdy),
    .overrun(ovr), .clr_ovr(clr)
  );

  sd_bitstream_decimator #(.DECIM_LOG2(6), .BITWIDTH(W)) dut64 (
    .clk(clk), .reset(rst64), .en(en64), .sd_in(sd64),
    .dout(dout64), .dout_valid(vld64), .dout_ready(rdy64),
    .overrun(ovr64), .clr_ovr(clr64)
  );

  function automatic int xval(logic [2:0] s);
    return (s[0] ? 1 : -1) + (s[1] ? 1 : -1) + (s[2] ? 1 : -1);
  endfunction

  // Reference: sinc2 == triangular FIR of length 2D-1 over
  // every enabled input since reset.
  int xs[$];
  bit m_v, m_o;
  int m_d;

  function automatic int sinc2();
    int acc = 0;
    int n = xs.size();
    for (int m = 0; m < 2*D-1; m++) begin
      int h = (m < D) ? m + 1 : 2*D - 1 - m;
      acc += h * xs[n-1-m];
    end
    return acc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs.delete();
      m_v = 1'b0;
      m_o = 1'b0;
      m_d = 0;
    end else begin
      bit has;
      bit set;
      int nv;
      has = 1'b0;
      set = 1'b0;
      nv  = 0;
      if (en) begin
        xs.push_back(xval(sd));
        if (xs.size() % D == 0 && xs.size() / D >= 3) begin
          has = 1'b1;
          nv  = sinc2();
        end
      end
      if (has) begin
        if (!m_v || rdy) begin
          m_d = nv;
          m_v = 1'b1;
        end else begin
          set = 1'b1;
        end
      end else if (m_v && rdy) begin
        m_v = 1'b0;
      end
      if (set) m_o = 1'b1;
      else if (clr) m_o = 1'b0;
    end
  end

  always @(negedge clk) begin
    tests++;
    if (vld !== m_v || ovr !== m_o || $signed(dout) !== m_d) begin
      fails++;
      if (nprint < 30) begin
        nprint++;
        $display("FAIL model t=%0t got dout=%0d v=%b ovr=%b required dout=%0d v=%b ovr=%b",
                 $time, $signed(dout), vld, ovr, m_d, m_v, m_o);
      end
    end
  end

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (nprint < 30) begin
        nprint++;
        $display("FAIL %s got %0d required %0d", nm, act, exp);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(int bound, output int n);
    n = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      n++;
      if (vld) break;
    end
  endtask

  task automatic run(int n, int mode, output int last);
    last = 32'h7fff_ffff;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (vld) last = $signed(dout);
      if (mode == 1) sd = (sd == 3'b111) ? 3'b000 : 3'b111;
    end
  endtask

  task automatic run64();
    int nv = 0;
    rst64 = 1'b0;
    en64  = 1'b1;
    sd64  = 3'b111;
    rdy64 = 1'b1;
    clr64 = 1'b0;
    repeat (2) @(negedge clk);
    rst64 = 1'b1;
    repeat (10000) begin
      @(negedge clk);
      if (vld64) begin
        nv++;
        chk("d64_dout", $signed(dout64), 12288);
      end
    end
    chk("d64_count", nv, 154);
    chk("d64_ovr", ovr64, 0);
  endtask

  task automatic main_seq();
    int n;
    int last;
    rst_n = 1'b0;
    en    = 1'b0;
    sd    = 3'b000;
    rdy   = 1'b1;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_valid", vld, 0);
    chk("rst_ovr", ovr, 0);

    sd = 3'b111;
    en = 1'b1;
    rst_n = 1'b1;
    wait_valid(40, n);
    chk("first_valid_cycle", n, 24);
    chk("dout_111_first", $signed(dout), 192);
    run(40, 0, last);
    chk("dout_111", last, 192);

    do_reset();
    sd = 3'b000;
    run(40, 0, last);
    chk("dout_000", last, -192);
    chk("dout_000_hex", dout, 32'hFFFF_FF40);

    sd = 3'b011;
    run(40, 0, last);
    chk("dout_011", last, 64);

    run(48, 1, last);
    chk("dout_alt", last, 0);

    rdy = 1'b0;
    sd  = 3'b111;
    do_reset();
    wait_valid(40, n);
    chk("bp_first_cycle", n, 24);
    run(10, 0, last);
    chk("bp_valid", vld, 1);
    chk("bp_dout", $signed(dout), 192);
    chk("bp_ovr", ovr, 1);
    rdy = 1'b1;
    @(negedge clk);
    chk("bp_xfer_valid", vld, 0);
    chk("bp_ovr_sticky", ovr, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_ovr", ovr, 0);

    rdy = 1'b0;
    run(20, 0, last);
    chk("pre_rst_valid", vld, 1);
    chk("pre_rst_ovr", ovr, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_valid", vld, 0);
    chk("arst_ovr", ovr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdy = 1'b1;
    wait_valid(40, n);
    chk("rerun_first_cycle", n, 24);
    chk("rerun_dout", $signed(dout), 192);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sd  = 3'($urandom);
      en  = ($urandom_range(0, 9) < 8);
      rdy = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 19) == 0);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #6 rst_n = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    fork
      main_seq();
      run64();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
